// File: rtl/urv_pipe_ctrl_if.sv
// rtl/urv_pipe_ctrl_if.sv - stall/kill/flush signal bundle between pipeline stages and urv_pipe_ctrl
interface urv_pipe_ctrl_if #(
  parameter int g_num_stages = 4
) ();
  logic [g_num_stages-1:0] stall_req_i;
  logic                    branch_i;
  logic                    flush_req_i;
  logic                    mem_busy_i;
  logic [g_num_stages-1:0] stall_o;
  logic [g_num_stages-1:0] kill_o;
  logic                    flush_busy_o;
  logic                    flush_done_o;

  modport master (
    output stall_req_i, branch_i, flush_req_i, mem_busy_i,
    input  stall_o, kill_o, flush_busy_o, flush_done_o
  );

  modport slave (
    input  stall_req_i, branch_i, flush_req_i, mem_busy_i,
    output stall_o, kill_o, flush_busy_o, flush_done_o
  );
endinterface

// File: rtl/urv_pipe_ctrl.sv
// rtl/urv_pipe_ctrl.sv - N-stage stall/kill controller with drain-then-flush sequencer
// Optional performance counters enabled by defining URV_PIPE_PERF_COUNTERS_EN.
module urv_pipe_ctrl #(
  parameter int g_num_stages = 4,
  parameter int g_exec_stage = 2,
  parameter int g_perf_width = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
`ifdef URV_PIPE_PERF_COUNTERS_EN
  input  logic                    perf_clear_i,
  output logic [g_perf_width-1:0] perf_stall_cycles_o,
  output logic [g_perf_width-1:0] perf_kill_events_o,
`endif
  urv_pipe_ctrl_if.slave          pipe
);

  localparam int CW = $clog2(g_exec_stage + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_KILL} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [g_exec_stage-1:0] bra_hist_q, bra_hist_d;
  logic [g_num_stages-1:0] stall_norm, kill_bra, stall, kill;
  logic                    upper_busy, flush_done;

  // Stall propagates backwards; stages from exec upward also honour their own request.
  always_comb begin
    logic acc;
    acc        = 1'b0;
    stall_norm = '0;
    kill_bra   = '0;
    upper_busy = pipe.mem_busy_i;
    for (int k = g_num_stages - 1; k >= 0; k--) begin
      stall_norm[k] = acc | ((k >= g_exec_stage) ? pipe.stall_req_i[k] : 1'b0);
      acc           = acc | pipe.stall_req_i[k];
      if (k > g_exec_stage) upper_busy = upper_busy | pipe.stall_req_i[k];
    end
    for (int k = 1; k <= g_exec_stage; k++) begin
      kill_bra[k] = pipe.branch_i;
      for (int j = 0; j < k; j++) kill_bra[k] = kill_bra[k] | bra_hist_q[j];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall      = stall_norm;
    kill       = kill_bra;
    flush_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pipe.flush_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        stall[g_exec_stage:0] = '1;
        if (!upper_busy) begin
          state_d = ST_KILL;
          cnt_d   = CW'(g_exec_stage);
        end
      end
      ST_KILL: begin
        stall[g_exec_stage:0] = '0;
        kill[g_exec_stage:0]  = '1;
        if (cnt_q == '0) begin
          state_d    = ST_IDLE;
          flush_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Branches seen while a flush is in progress never enter the history.
  always_comb begin
    bra_hist_d = bra_hist_q;
    if (state_q == ST_KILL && cnt_q == '0) begin
      bra_hist_d = '0;
    end else if (!stall[g_exec_stage]) begin
      bra_hist_d[0] = pipe.branch_i & (state_q == ST_IDLE);
      for (int i = 1; i < g_exec_stage; i++) bra_hist_d[i] = bra_hist_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bra_hist_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bra_hist_q <= bra_hist_d;
    end
  end

  assign pipe.stall_o      = stall;
  assign pipe.kill_o       = kill;
  assign pipe.flush_busy_o = (state_q != ST_IDLE);
  assign pipe.flush_done_o = flush_done;

`ifdef URV_PIPE_PERF_COUNTERS_EN
  logic                    kill_exec_q;
  logic [g_perf_width-1:0] stall_cnt_q, kill_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kill_exec_q <= 1'b0;
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      kill_exec_q <= kill[g_exec_stage];
      if (perf_clear_i) begin
        stall_cnt_q <= '0;
        kill_cnt_q  <= '0;
      end else begin
        if (stall[0]) stall_cnt_q <= stall_cnt_q + 1'b1;
        if (kill[g_exec_stage] && !kill_exec_q) kill_cnt_q <= kill_cnt_q + 1'b1;
      end
    end
  end

  assign perf_stall_cycles_o = stall_cnt_q;
  assign perf_kill_events_o  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// tb/tb_urv_pipe_ctrl.sv - directed self-checking bench for urv_pipe_ctrl (4/2 and 6/3 configurations)
module tb_urv_pipe_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk_i = ~clk_i;

  urv_pipe_ctrl_if #(.g_num_stages(4)) a_if ();
  urv_pipe_ctrl_if #(.g_num_stages(6)) b_if ();

`ifdef URV_PIPE_PERF_COUNTERS_EN
  logic        a_clr = 1'b0;
  logic        b_clr = 1'b0;
  logic [31:0] a_stall_cnt, a_kill_cnt, b_stall_cnt, b_kill_cnt;
`endif

  urv_pipe_ctrl #(.g_num_stages(4), .g_exec_stage(2), .g_perf_width(32)) u_dut_a (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
`ifdef URV_PIPE_PERF_COUNTERS_EN
    .perf_clear_i        (a_clr),
    .perf_stall_cycles_o (a_stall_cnt),
    .perf_kill_events_o  (a_kill_cnt),
`endif
    .pipe                (a_if.slave)
  );

  urv_pipe_ctrl #(.g_num_stages(6), .g_exec_stage(3), .g_perf_width(32)) u_dut_b (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
`ifdef URV_PIPE_PERF_COUNTERS_EN
    .perf_clear_i        (b_clr),
    .perf_stall_cycles_o (b_stall_cnt),
    .perf_kill_events_o  (b_kill_cnt),
`endif
    .pipe                (b_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k1, k3, kother;
    a_if.stall_req_i = '0; a_if.branch_i = 0; a_if.flush_req_i = 0; a_if.mem_busy_i = 0;
    b_if.stall_req_i = '0; b_if.branch_i = 0; b_if.flush_req_i = 0; b_if.mem_busy_i = 0;
    tick(); tick();
    settle();
    check("rst_stall", 32'(a_if.stall_o), 32'h0);
    check("rst_kill", 32'(a_if.kill_o), 32'h0);
    check("rst_busy", 32'(a_if.flush_busy_o), 32'h0);
    check("rst_done", 32'(a_if.flush_done_o), 32'h0);
`ifdef URV_PIPE_PERF_COUNTERS_EN
    check("rst_perf_stall", a_stall_cnt, 32'h0);
    check("rst_perf_kill", a_kill_cnt, 32'h0);
`endif
    tick(); rst_i = 0;

    // combinational stall patterns
    a_if.stall_req_i = 4'b0100; settle();
    check("stall_x", 32'(a_if.stall_o), 32'h7);
    check("stall_x_kill", 32'(a_if.kill_o), 32'h0);
    tick(); a_if.stall_req_i = 4'b0010; settle();
    check("stall_d", 32'(a_if.stall_o), 32'h1);
    tick(); a_if.stall_req_i = 4'b1000; settle();
    check("stall_w", 32'(a_if.stall_o), 32'hf);
    tick(); a_if.stall_req_i = 4'b0001; settle();
    check("stall_f", 32'(a_if.stall_o), 32'h0);
    tick(); a_if.stall_req_i = 4'b0000;

    // single branch pulse, no stalls
    a_if.branch_i = 1; settle();
    check("br_t0", 32'(a_if.kill_o), 32'h6);
    tick(); a_if.branch_i = 0; settle();
    check("br_t1", 32'(a_if.kill_o), 32'h6);
    tick(); settle();
    check("br_t2", 32'(a_if.kill_o), 32'h4);
    tick(); settle();
    check("br_t3", 32'(a_if.kill_o), 32'h0);

    // branch then writeback stall: history frozen
    tick(); a_if.branch_i = 1; settle();
    check("brs_t0", 32'(a_if.kill_o), 32'h6);
    tick(); a_if.branch_i = 0; a_if.stall_req_i = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("brs_frozen", 32'(a_if.kill_o), 32'h6);
      check("brs_stall", 32'(a_if.stall_o), 32'hf);
      tick();
    end
    a_if.stall_req_i = 4'b0000; settle();
    check("brs_u1", 32'(a_if.kill_o), 32'h6);
    tick(); settle();
    check("brs_u2", 32'(a_if.kill_o), 32'h4);
    tick(); settle();
    check("brs_u3", 32'(a_if.kill_o), 32'h0);

    // flush with memory busy for 5 cycles
    tick(); a_if.flush_req_i = 1; a_if.mem_busy_i = 1; settle();
    check("fl_idle_busy", 32'(a_if.flush_busy_o), 32'h0);
    tick(); a_if.flush_req_i = 0;
    for (int i = 0; i < 5; i++) begin
      a_if.mem_busy_i = (i < 4);
      settle();
      check("fl_drain_stall", 32'(a_if.stall_o), 32'h7);
      check("fl_drain_busy", 32'(a_if.flush_busy_o), 32'h1);
      check("fl_drain_done", 32'(a_if.flush_done_o), 32'h0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      settle();
      check("fl_kill_kill", 32'(a_if.kill_o), 32'h7);
      check("fl_kill_stall", 32'(a_if.stall_o), 32'h0);
      check("fl_kill_done", 32'(a_if.flush_done_o), (i == 2) ? 32'h1 : 32'h0);
      tick();
    end
    settle();
    check("fl_end_busy", 32'(a_if.flush_busy_o), 32'h0);
    check("fl_end_kill", 32'(a_if.kill_o), 32'h0);

    // reset during KILL
    tick(); a_if.flush_req_i = 1; settle();
    tick(); a_if.flush_req_i = 0; settle();
    check("rk_drain", 32'(a_if.flush_busy_o), 32'h1);
    tick(); rst_i = 1; settle();
    check("rk_in_kill", 32'(a_if.kill_o), 32'h7);
    tick(); rst_i = 0; settle();
    check("rk_busy", 32'(a_if.flush_busy_o), 32'h0);
    check("rk_kill", 32'(a_if.kill_o), 32'h0);
    check("rk_stall", 32'(a_if.stall_o), 32'h0);
    check("rk_done", 32'(a_if.flush_done_o), 32'h0);
    tick(); settle();
    check("rk_done2", 32'(a_if.flush_done_o), 32'h0);

`ifdef URV_PIPE_PERF_COUNTERS_EN
    tick(); a_clr = 1; a_if.stall_req_i = 4'b0010;
    tick(); a_clr = 0; settle();
    check("perf_clr_prio", a_stall_cnt, 32'h0);
    tick(); tick(); tick(); a_if.stall_req_i = 4'b0000; settle();
    check("perf_stall3", a_stall_cnt, 32'h3);
`endif

    // six-stage configuration, exec at 3
    tick(); b_if.branch_i = 1; settle();
    check("b6_t0", 32'(b_if.kill_o), 32'he);
    k1 = 0; k3 = 0; kother = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) settle();
      k1 += int'(b_if.kill_o[1]);
      k3 += int'(b_if.kill_o[3]);
      kother += int'(b_if.kill_o[0] | b_if.kill_o[4] | b_if.kill_o[5]);
      tick(); b_if.branch_i = 0;
    end
    check("b6_k3_cycles", 32'(k3), 32'h4);
    check("b6_k1_cycles", 32'(k1), 32'h2);
    check("b6_other", 32'(kother), 32'h0);
`ifdef URV_PIPE_PERF_COUNTERS_EN
    settle();
    check("b6_perf_kill", b_kill_cnt, 32'h1);
    check("b6_perf_stall", b_stall_cnt, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
